spi_pixel_packer: RTL
=====================

// Module: spi_pixel_packer
// PURPOSE
//  Sits between the SPI slave byte receiver and sram_wrapper's SPI/ADC-style pixel input.
//  Assembles RGB565 pixels from an SPI byte stream, MSB byte first.
//  Tags each pixel with auto-incrementing raster coordinates and buffers it in a FIFO.
//  Output is a 38-bit {x,y,rgb} word, the same format as the ADC pixel FIFO.
//  This lets SRAM writes wait out foreground read bursts instead of being lost.
// PARAMETERS
//  X_RES       800  image width; x wraps to 0 after X_RES-1
//  Y_RES       600  image height; y wraps to 0 after Y_RES-1
//  FIFO_DEPTH  16   entries, power of two, >=2
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous, active-high reset
//  spi_frame_start in   1   1-cycle pulse: new image begins, coords/phase cleared
//  spi_byte_valid  in   1   spi_byte holds a received byte this cycle
//  spi_byte        in   8   received byte
//  pixel_data      out  38  {x[10:0], y[10:0], rgb565[15:0]} at FIFO head
//  pixel_ready     out  1   FIFO non-empty; pixel_data valid
//  pixel_read      in   1   consume head entry (ignored when !pixel_ready)
//  image_done      out  1   1-cycle pulse when pixel (X_RES-1,Y_RES-1) is assembled
//  overflow        out  1   sticky: a pixel was dropped because FIFO was full
// BEHAVIOUR
//  - Reset: pixel_ready=0, image_done=0, overflow=0, FIFO emptied, x=y=0, phase=HI.
//    pixel_data is don't-care while !pixel_ready.
//  - Phase FSM, 2 states:
//    - HI: on a valid byte, latch it into hi_byte and go to LO.
//    - LO: on a valid byte, form pixel {hi_byte, byte}, push it with the current x,y, and return to HI.
//  - Coordinate advance happens per assembled pixel, whether or not the push succeeded:
//    - x < X_RES-1: x++.
//    - Otherwise x=0 and y++; if y was Y_RES-1, y=0 and image_done pulses in the same cycle as the push.
//  - spi_frame_start has priority. It sets x=y=0 and phase=HI before any same-cycle byte is processed.
//    A coincident byte is therefore the HI byte of the new image's pixel (0,0).
//  - Latency: the LO byte is sampled at edge N, and the entry is written at edge N.
//    pixel_ready is high after edge N; first-word-fall-through, pixel_data valid with it.
//  - Pop: pixel_read && pixel_ready at edge M advances the head.
//    The next entry, if any, is visible after edge M.
//  - Full + push + pop in the same cycle: push is accepted and count is unchanged.
//  - Full + push, no pop: pixel is dropped, overflow<=1 (sticky until rst), coordinates still advance.
//  - Empty + pop: ignored; count never underflows.
//  - Empty + push + pop: the pop is ignored (pixel_ready was 0) and the push lands.
//  - Occupancy count is $clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
//  - rst mid-operation discards a half-assembled pixel and all buffered entries.
// CONFIGURATION
//  - SPI_PACKER_BGR_SWAP_EN defined:
//    pixel rgb565 is stored as {b[4:0], g[5:0], r[4:0]} (red/blue fields swapped) for BGR-ordered host tools.
//  - Not defined: stored as received, {r, g, b}.
//  - Ports and latency are identical in both builds.
// STRUCTURE
//  - Shared include pixel_defs.vh:
//    - COORD_W=11, RGB_W=16, PIXEL_W=38
//    - field offsets PIX_X_LSB=27, PIX_Y_LSB=16
//    - phase state encodings PH_HI/PH_LO
//  - One sub-module: sync_fifo (params WIDTH, DEPTH; push, pop, full, empty, dout, FWFT).
//    Also reusable for the ADC path.
//  - Top level holds the phase FSM, coordinate counters, overflow flag and optional swap.
// TESTING
//  1. rst, then bytes 0xF8,0x00,0x07,0xE0 ->
//     entries {x0,y0,0xF800} then {x1,y0,0x07E0}; pixel_ready 1 cycle after the 2nd byte.
//  2. Stream X_RES*Y_RES pixels, pixel_read held 1 ->
//     last entry x=799,y=599; image_done single pulse; next pixel is (0,0).
//  3. pixel_read=0, push FIFO_DEPTH+1 pixels ->
//     overflow=1, 16 entries are pixels 0..15, pixel 16 dropped; next push gets x=17.
//  4. Full FIFO, push and pixel_read in same cycle -> count stays 16, overflow stays 0, tail is new pixel.
//  5. Send HI byte only, then spi_frame_start with a coincident byte 0xAB, then byte 0xCD ->
//     entry {x0,y0,0xABCD}.
//  6. With SPI_PACKER_BGR_SWAP_EN, send bytes 0xF8,0x00 -> stored rgb 0x001F.

Source files
------------

// File: rtl/spi_pixel_packer_pkg.sv
// Shared definitions for the SPI pixel packer.
// Holds the coordinate/pixel widths, the field offsets of the 38-bit
// {x, y, rgb565} FIFO word (same layout as the ADC pixel FIFO), the
// byte-phase state encoding and the red/blue swap helper.
package spi_pixel_packer_pkg;

    localparam int COORD_W   = 11;
    localparam int RGB_W     = 16;
    localparam int PIXEL_W   = 38;
    localparam int PIX_X_LSB = 27;
    localparam int PIX_Y_LSB = 16;

    // HI: waiting for the first (MSB) byte of a pixel.
    // LO: first byte held, the next byte completes the pixel.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    // {r,g,b} -> {b,g,r}; the 6-bit green field stays in the middle.
    function automatic logic [RGB_W-1:0] swap_rb(input logic [RGB_W-1:0] rgb);
        return {rgb[4:0], rgb[10:5], rgb[15:11]};
    endfunction

endpackage

// File: rtl/spi_pixel_packer_if.sv
// Bus bundle between the SPI byte receiver, the packer and the SRAM
// pixel consumer.
//   spi_frame_start : 1-cycle pulse, new image begins
//   spi_byte_valid  : spi_byte holds a received byte this cycle
//   spi_byte        : received byte
//   pixel_data      : {x, y, rgb565} at FIFO head (valid while pixel_ready)
//   pixel_ready     : FIFO non-empty
//   pixel_read      : consume head entry (ignored while !pixel_ready)
//   image_done      : 1-cycle pulse when the last pixel of an image is assembled
//   overflow        : sticky, a pixel was dropped because the FIFO was full
//   phase_dbg       : current byte-phase state, for observation only
// Handshake: an entry is transferred at a rising clock edge where
// pixel_ready && pixel_read are both high; pixel_data must not be consumed
// otherwise, and pixel_read while !pixel_ready has no effect.
interface spi_pixel_packer_if
    import spi_pixel_packer_pkg::*;
();
    logic               spi_frame_start;
    logic               spi_byte_valid;
    logic [7:0]         spi_byte;
    logic [PIXEL_W-1:0] pixel_data;
    logic               pixel_ready;
    logic               pixel_read;
    logic               image_done;
    logic               overflow;
    phase_e             phase_dbg;

    modport master (
        output spi_frame_start, spi_byte_valid, spi_byte, pixel_read,
        input  pixel_data, pixel_ready, image_done, overflow, phase_dbg
    );

    modport slave (
        input  spi_frame_start, spi_byte_valid, spi_byte, pixel_read,
        output pixel_data, pixel_ready, image_done, overflow, phase_dbg
    );
endinterface

// File: rtl/spi_pixel_packer_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push_i   : write din_i (accepted when not full, or when full and a pop
//              happens in the same cycle)
//   din_i    : write data
//   pop_i    : advance the head (ignored while empty)
//   dout_o   : head entry, valid whenever empty_o is low
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/spi_pixel_packer.sv
// spi_pixel_packer: assembles RGB565 pixels from an SPI byte stream (MSB
// byte first), tags each with raster coordinates and buffers it in a FIFO
// as a 38-bit {x, y, rgb565} word for the SRAM writer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : spi_pixel_packer_if.slave (byte input, FIFO output, status)
// Build option: define SPI_PACKER_BGR_SWAP_EN to store pixels as
// {b, g, r}; otherwise they are stored as received, {r, g, b}.
module spi_pixel_packer
    import spi_pixel_packer_pkg::*;
#(
    parameter int X_RES      = 800,
    parameter int Y_RES      = 600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    spi_pixel_packer_if.slave   bus
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_RES - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_RES - 1);

    phase_e             phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               push, done;
    logic [RGB_W-1:0]   rgb_raw, rgb_store;
    logic [PIXEL_W-1:0] entry;
    logic               fifo_full, fifo_empty, pop_eff;

    assign rgb_raw = {hi_q, bus.spi_byte};
`ifdef SPI_PACKER_BGR_SWAP_EN
    assign rgb_store = swap_rb(rgb_raw);
`else
    assign rgb_store = rgb_raw;
`endif
    // A pushed pixel always comes from the LO phase, where frame_start cannot
    // be in effect, so the registered coordinates are the pixel's own.
    assign entry   = {x_q, y_q, rgb_store};
    assign pop_eff = bus.pixel_read && !fifo_empty;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        done    = 1'b0;
        // Frame start is applied first so a coincident byte becomes the HI
        // byte of pixel (0,0) of the new image.
        if (bus.spi_frame_start) begin
            phase_d = PH_HI;
            x_d     = '0;
            y_d     = '0;
        end
        if (bus.spi_byte_valid) begin
            if (phase_d == PH_HI) begin
                hi_d    = bus.spi_byte;
                phase_d = PH_LO;
            end else begin
                push    = 1'b1;
                phase_d = PH_HI;
                // Coordinates advance even if the FIFO drops the pixel.
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d  = '0;
                        done = 1'b1;
                    end else begin
                        y_d = y_q + COORD_W'(1);
                    end
                end else begin
                    x_d = x_q + COORD_W'(1);
                end
            end
        end
        if (push && fifo_full && !pop_eff) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_HI;
            hi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (entry),
        .pop_i   (bus.pixel_read),
        .dout_o  (bus.pixel_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.pixel_ready = !fifo_empty;
    assign bus.image_done  = done;
    assign bus.overflow    = ovf_q;
    assign bus.phase_dbg   = phase_q;
endmodule
